// File: rtl/mcif_wr_arb_pkg.sv
// Shared constants for the MCIF write arbiter: packed request layout,
// FSM encodings and width helpers.
package mcif_wr_arb_pkg;

    localparam int LEN_LSB = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    function automatic int req_w(input int len_w, input int dat_w);
        return 2 + len_w + 32 + dat_w;
    endfunction

    function automatic int cmd_flag_bit(input int req_w_v);
        return req_w_v - 1;
    endfunction

    function automatic int np_bit(input int len_w);
        return LEN_LSB + len_w;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcif_wr_arb_idfifo.sv
// FIFO of requester IDs for outstanding non-posted writes.
// A push is accepted while full only if a pop happens in the same cycle.
module mcif_wr_arb_idfifo
    import mcif_wr_arb_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [ID_W-1:0] i_id,
    input  logic            i_pop,
    output logic [ID_W-1:0] o_head,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ID_W-1:0] r_mem [DEPTH];
    logic [AW:0]     r_wp;
    logic [AW:0]     r_rp;
    logic            w_wr;
    logic            w_rd;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_head  = r_mem[r_rp[AW-1:0]];
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_id;
    end

endmodule

// File: rtl/mcif_wr_arb.sv
// Round-robin burst arbiter for the MCIF write request port.
// Optional per-requester data beat counters: MCIF_WR_ARB_PERF_EN.
module mcif_wr_arb
    import mcif_wr_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int LEN_W    = 4,
    parameter  int DAT_W    = 512,
    parameter  int NP_DEPTH = 4,
    localparam int REQ_W    = req_w(LEN_W, DAT_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ*REQ_W-1:0] req_pd,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [NUM_REQ-1:0]       req_complete,
    output logic                     mcif_wr_req_vld,
    input  logic                     mcif_wr_req_rdy,
    output logic [REQ_W-1:0]         mcif_wr_req_pd,
    input  logic                     mcif_wr_rsp_complete,
    output logic                     arb_err
`ifdef MCIF_WR_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]    perf_beats
`endif
);

    localparam int IDW = id_w(NUM_REQ);
    localparam int CFB = cmd_flag_bit(REQ_W);
    localparam int NPB = np_bit(LEN_W);

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_gnt;
    logic [IDW-1:0]     r_rr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_err;
    logic [NUM_REQ-1:0] r_cmpl;

    logic [NUM_REQ-1:0] w_elig;
    logic [IDW-1:0]     w_win;
    logic [REQ_W-1:0]   w_pd_g;
    logic               w_act;
    logic               w_blk;
    logic               w_hs;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [IDW-1:0]     w_head;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            w_elig[i] = req_vld[i] && req_pd[i*REQ_W+CFB];
    end

    // Scan downwards so the lowest offset from the pointer wins.
    always_comb begin
        int idx;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (w_elig[idx[IDW-1:0]]) w_win = idx[IDW-1:0];
        end
    end

    assign w_pd_g = req_pd[int'(r_gnt)*REQ_W +: REQ_W];
    assign w_act  = (r_state == ST_CMD) || (r_state == ST_DATA);
    assign w_blk  = (r_state == ST_CMD) && w_pd_g[NPB] && w_full;

    assign mcif_wr_req_vld = w_act && req_vld[r_gnt] && !w_blk;
    assign mcif_wr_req_pd  = w_act ? w_pd_g : '0;

    always_comb begin
        req_rdy = '0;
        if (w_act && !w_blk) req_rdy[r_gnt] = mcif_wr_req_rdy;
    end

    assign w_hs   = mcif_wr_req_vld && mcif_wr_req_rdy;
    assign w_last = (r_state == ST_DATA) && w_hs && (r_cnt == r_len);
    assign w_push = (r_state == ST_CMD) && w_hs && w_pd_g[NPB];
    assign w_pop  = mcif_wr_rsp_complete && !w_empty;

    mcif_wr_arb_idfifo #(
        .ID_W  (IDW),
        .DEPTH (NP_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_id    (r_gnt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_rr    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_elig) begin
                        r_gnt   <= w_win;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_hs) begin
                        r_len   <= w_pd_g[LEN_LSB +: LEN_W];
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_rr    <= (int'(r_gnt) == NUM_REQ - 1) ?
                                   '0 : r_gnt + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= 1'b0;
            r_cmpl <= '0;
        end else begin
            r_cmpl <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
            if ((mcif_wr_rsp_complete && w_empty) ||
                ((r_state == ST_DATA) && w_hs && w_pd_g[CFB]))
                r_err <= 1'b1;
        end
    end

    assign req_complete = r_cmpl;
    assign arb_err      = r_err;

`ifdef MCIF_WR_ARB_PERF_EN
    logic [31:0] r_perf [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_perf[i] <= '0;
        end else if ((r_state == ST_DATA) && w_hs) begin
            r_perf[r_gnt] <= r_perf[r_gnt] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_beats[g*32 +: 32] = r_perf[g];
    end
`endif

endmodule

// File: tb/tb_mcif_wr_arb.sv
// Directed and randomized bench for mcif_wr_arb against a
// transaction-level round-robin / completion-routing model.
module tb_mcif_wr_arb;

    localparam int NR  = 4;
    localparam int LW  = 4;
    localparam int DW  = 32;
    localparam int ND  = 4;
    localparam int RW  = 2 + LW + 32 + DW;
    localparam int NPB = 32 + LW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_vld;
    logic [NR*RW-1:0] req_pd;
    logic [NR-1:0]    req_rdy;
    logic [NR-1:0]    req_complete;
    logic             mvld;
    logic             mrdy;
    logic [RW-1:0]    mpd;
    logic             mcmpl;
    logic             err;
`ifdef MCIF_WR_ARB_PERF_EN
    logic [NR*32-1:0] perf_beats;
    int               m_perf [NR];
`endif

    always #5 clk = ~clk;

    mcif_wr_arb #(
        .NUM_REQ  (NR),
        .LEN_W    (LW),
        .DAT_W    (DW),
        .NP_DEPTH (ND)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_vld              (req_vld),
        .req_pd               (req_pd),
        .req_rdy              (req_rdy),
        .req_complete         (req_complete),
        .mcif_wr_req_vld      (mvld),
        .mcif_wr_req_rdy      (mrdy),
        .mcif_wr_req_pd       (mpd),
        .mcif_wr_rsp_complete (mcmpl),
        .arb_err              (err)
`ifdef MCIF_WR_ARB_PERF_EN
        ,
        .perf_beats           (perf_beats)
`endif
    );

    // Requester traffic and reference model state
    logic [RW-1:0] rq [NR][$];
    int            npq[$];
    bit            m_idle;
    int            m_own;
    int            m_rr;
    int            m_stage;
    int            m_rem;
    logic [NR-1:0] m_cmpl;
    logic          m_err;

    bit            rand_vld;
    int            rdy_mode;
    bit            do_cmpl;
    bit            rand_cmpl;
    int            glog[$];
    int            cmpl_log[$];
    logic [NR-1:0] last_cmpl;
    int            d_hs;
    int            vecs;
    int            errs;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) rq[i].delete();
        npq.delete();
        m_idle = 1'b1;
        m_own  = 0;
        m_rr   = 0;
        m_stage = 0;
        m_rem  = 0;
        m_cmpl = '0;
        m_err  = 1'b0;
`ifdef MCIF_WR_ARB_PERF_EN
        for (int i = 0; i < NR; i++) m_perf[i] = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req_vld = '0;
        req_pd  = '0;
        mcmpl   = 1'b0;
        mrdy    = 1'b0;
        #1;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_mcif_vld", mvld, 0);
        chk("rst_mcif_pd", mpd, 0);
        chk("rst_req_complete", req_complete, 0);
        chk("rst_arb_err", err, 0);
`ifdef MCIF_WR_ARB_PERF_EN
        chk("rst_perf", perf_beats[RW-1:0], 0);
        chk("rst_perf_hi", perf_beats[NR*32-1:RW], 0);
`endif
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_burst(input int i, input int len, input bit np);
        logic [95:0]   r;
        logic [RW-1:0] b;
        r = {$urandom, $urandom, $urandom};
        b = r[RW-1:0];
        b[RW-1] = 1'b1;
        b[NPB]  = np;
        b[NPB-1:32] = len[LW-1:0];
        rq[i].push_back(b);
        for (int j = 0; j <= len; j++) begin
            r = {$urandom, $urandom, $urandom};
            b = r[RW-1:0];
            b[RW-1] = 1'b0;
            rq[i].push_back(b);
        end
    endtask

    task automatic step();
        logic [NR-1:0] v;
        logic [NR-1:0] el;
        logic [NR-1:0] exp_rdy;
        logic [RW-1:0] exp_pd;
        logic [RW-1:0] f;
        logic [RW-1:0] b;
        logic          exp_vld;
        logic          blk;
        logic          hs;
        logic          c;
        int            w;
        int            idx;
        @(negedge clk);
        el = '0;
        for (int i = 0; i < NR; i++) begin
            f = (rq[i].size() != 0) ? rq[i][0] : '0;
            v[i] = (rq[i].size() != 0) &&
                   (!rand_vld || $urandom_range(3) != 0);
            el[i] = v[i] && f[RW-1];
            req_pd[i*RW +: RW] = f;
        end
        req_vld = v;
        case (rdy_mode)
            0:       mrdy = 1'b1;
            1:       mrdy = 1'($urandom_range(1));
            default: mrdy = ~mrdy;
        endcase
        c = do_cmpl || (rand_cmpl && npq.size() != 0 &&
                        $urandom_range(3) == 0);
        do_cmpl = 1'b0;
        mcmpl = c;
        #1;
        exp_rdy = '0;
        exp_vld = 1'b0;
        exp_pd  = '0;
        blk     = 1'b0;
        if (!m_idle) begin
            f = rq[m_own][0];
            blk = (m_stage == 0) && f[NPB] && (npq.size() == ND);
            exp_rdy[m_own] = mrdy && !blk;
            exp_vld = v[m_own] && !blk;
            exp_pd  = f;
        end
        chk("req_rdy", req_rdy, exp_rdy);
        chk("mcif_vld", mvld, exp_vld);
        chk("mcif_pd", mpd, exp_pd);
        chk("req_complete", req_complete, m_cmpl);
        chk("arb_err", err, m_err);
        last_cmpl = req_complete;
        for (int i = 0; i < NR; i++)
            if (req_complete[i]) cmpl_log.push_back(i);
        if (mvld && mrdy) begin
            if (mpd[RW-1]) begin
                for (int i = 0; i < NR; i++)
                    if (req_rdy[i]) glog.push_back(i);
            end else begin
                d_hs++;
            end
        end
        m_cmpl = '0;
        if (c) begin
            if (npq.size() != 0) m_cmpl[npq.pop_front()] = 1'b1;
            else m_err = 1'b1;
        end
        hs = !m_idle && v[m_own] && mrdy && !blk;
        if (m_idle) begin
            if (el != 0) begin
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_rr + k) % NR;
                    if (w < 0 && el[idx]) w = idx;
                end
                m_own   = w;
                m_idle  = 1'b0;
                m_stage = 0;
            end
        end else if (hs) begin
            b = rq[m_own].pop_front();
            if (m_stage == 0) begin
                m_rem = int'(b[NPB-1:32]) + 1;
                if (b[NPB]) npq.push_back(m_own);
                m_stage = 1;
            end else begin
                if (b[RW-1]) m_err = 1'b1;
`ifdef MCIF_WR_ARB_PERF_EN
                m_perf[m_own]++;
`endif
                m_rem--;
                if (m_rem == 0) begin
                    m_idle = 1'b1;
                    m_rr = (m_own + 1) % NR;
                end
            end
        end
    endtask

    function automatic int pending();
        int n = m_idle ? 0 : 1;
        for (int i = 0; i < NR; i++) n += rq[i].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", pending(), 0);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        rand_vld = 1'b0;
        rand_cmpl = 1'b0;
        do_cmpl = 1'b0;
        rdy_mode = 0;
        d_hs = 0;
        model_clear();
        do_reset();

        // Single non-posted burst from requester 1, then completion
        add_burst(1, 3, 1'b1);
        glog.delete();
        d_hs = 0;
        step();
        chk("A_grant_latency", mvld, 0);
        step();
        chk("A_cmd_beat", mvld && mpd[RW-1] && req_rdy[1], 1);
        drain(50);
        chk("A_data_beats", d_hs, 4);
        do_cmpl = 1'b1;
        step();
        step();
        chk("A_complete", last_cmpl, 4'b0010);
        glog.delete();
        add_burst(0, 1, 1'b0);
        add_burst(2, 1, 1'b0);
        drain(50);
        chk("A_rr_after_1", glog[0], 2);
        chk("A_rr_then_0", glog[1], 0);

        // Requesters 0 and 2 contending from reset
        do_reset();
        glog.delete();
        add_burst(0, 2, 1'b0);
        add_burst(0, 1, 1'b0);
        add_burst(2, 3, 1'b0);
        add_burst(2, 0, 1'b0);
        drain(100);
        chk("B_grant_count", glog.size(), 4);
        chk("B_grant0", glog[0], 0);
        chk("B_grant1", glog[1], 2);
        chk("B_grant2", glog[2], 0);
        chk("B_grant3", glog[3], 2);

        // 16-beat burst with MCIF ready toggling
        rdy_mode = 2;
        d_hs = 0;
        add_burst(3, 15, 1'b0);
        drain(100);
        chk("C_data_beats", d_hs, 16);
        rdy_mode = 0;

        // Fill the non-posted FIFO, fifth command must wait
        do_reset();
        add_burst(3, 0, 1'b1);
        drain(20);
        add_burst(1, 0, 1'b1);
        drain(20);
        add_burst(0, 0, 1'b1);
        drain(20);
        add_burst(2, 0, 1'b1);
        drain(20);
        add_burst(1, 0, 1'b1);
        for (int i = 0; i < 6; i++) step();
        chk("D_fifth_held", req_rdy, 0);
        cmpl_log.delete();
        for (int i = 0; i < 4; i++) begin
            do_cmpl = 1'b1;
            step();
            step();
        end
        drain(20);
        chk("D_cmpl_count", cmpl_log.size(), 4);
        chk("D_cmpl0", cmpl_log[0], 3);
        chk("D_cmpl1", cmpl_log[1], 1);
        chk("D_cmpl2", cmpl_log[2], 0);
        chk("D_cmpl3", cmpl_log[3], 2);

        // Randomized traffic with stalls and completions
        do_reset();
        rand_vld = 1'b1;
        rand_cmpl = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++)
            add_burst($urandom_range(NR - 1),
                      ($urandom_range(3) == 0) ? $urandom_range(15)
                                               : $urandom_range(3),
                      1'($urandom_range(1)));
        drain(20000);
        rand_vld = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 64 && npq.size() != 0; i++) step();
        rand_cmpl = 1'b0;
        chk("R_np_drained", npq.size(), 0);
        step();

        // Completion with nothing outstanding
        do_cmpl = 1'b1;
        step();
        step();
        chk("E_arb_err", err, 1);
        chk("E_no_pulse", last_cmpl, 0);

        // Reset in the middle of a data burst
        do_reset();
        add_burst(2, 15, 1'b0);
        for (int i = 0; i < 7; i++) step();
        do_reset();
        glog.delete();
        add_burst(3, 0, 1'b0);
        add_burst(0, 0, 1'b0);
        drain(50);
        chk("F_first_grant", glog[0], 0);

`ifdef MCIF_WR_ARB_PERF_EN
        for (int i = 0; i < NR; i++)
            chk("perf_beats", perf_beats[i*32 +: 32], m_perf[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mcif_wr_arb.md
Name: mcif_wr_arb

Overview:
- Round-robin arbiter that shares the single MCIF write request port between NUM_REQ write-DMA requesters (transpose, activation and weight write DMAs).
- Each requester sends one command beat, then length+1 data beats, all on one packed request bus.
- Once a requester wins, it keeps the port until its burst completes. Bursts are never interleaved.
- Write completions from MCIF are routed back to the requester that issued the matching non-posted command.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 4, burst length field width (log2 of AXI burst length).
- DAT_W, 512, data beat width (Tout*MAX_DAT_DW).
- NP_DEPTH, 4, depth of the non-posted requester-ID FIFO (power of 2).
- Derived localparam REQ_W = 2+LEN_W+32+DAT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NUM_REQ  per-requester request valid
- req_pd  in  NUM_REQ*REQ_W  per-requester packed request; requester i occupies slice [i*REQ_W +: REQ_W]
- req_rdy  out  NUM_REQ  per-requester ready
- req_complete  out  NUM_REQ  one-cycle completion pulse per requester
- mcif_wr_req_vld  out  1  request valid to MCIF
- mcif_wr_req_rdy  in  1  MCIF ready
- mcif_wr_req_pd  out  REQ_W  forwarded packed request
- mcif_wr_rsp_complete  in  1  completion pulse from MCIF
- arb_err  out  1  sticky protocol error flag
- (optional) perf_beats  out  NUM_REQ*32  see Optional Feature

Behaviour:
- Packed format, command beat:
  - pd[REQ_W-1] = 1 (command flag).
  - Length field at [32+LEN_W-1:32].
  - Non-posted bit at [32+LEN_W].
  - Data beats have pd[REQ_W-1] = 0.
- Reset values: state IDLE, RR pointer 0, FIFO empty, all outputs 0, pd 0.
- A requester is eligible when req_vld[i]=1 and pd[REQ_W-1]=1.
- FSM state IDLE:
  - If any requester is eligible, register the winner, going to CMD on the next cycle (one-cycle grant latency).
  - Winner selection: first eligible requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_rdy is all 0 in IDLE.
- FSM state CMD:
  - mcif_wr_req_vld = req_vld[g] and mcif_wr_req_pd = req_pd[g], where g is the granted requester.
  - req_rdy[g] = mcif_wr_req_rdy, except when the command is non-posted and the FIFO is full; then req_rdy[g] and vld are forced to 0.
  - On handshake: latch length into len_q, clear beat_cnt, push g into the FIFO if non-posted, go to DATA.
- FSM state DATA:
  - Same forwarding as CMD.
  - Each handshake increments beat_cnt.
  - The handshake with beat_cnt==len_q ends the burst: RR pointer = g+1 (mod NUM_REQ), go to IDLE. This gives a one-cycle bubble between bursts.
- Requester vld drop mid-burst: stall; vld to MCIF stays 0 and there is no timeout.
- Only the granted requester ever sees req_rdy=1.
- Data beats with pd[REQ_W-1]=1 arriving during DATA are forwarded anyway and set arb_err.
- Completion routing: on mcif_wr_rsp_complete, pop the FIFO head h and pulse req_complete[h] on the next cycle (registered).
  - Completion while the FIFO is empty: no pulse, set arb_err.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full.
- arb_err is cleared only by reset.
- Beat counters are LEN_W wide; len_q = 2^LEN_W-1 means a full-length burst.

Optional Feature:
- Macro MCIF_WR_ARB_PERF_EN.
- When defined:
  - Port perf_beats exists.
  - Holds per-requester 32-bit counters of forwarded data beats (handshakes in DATA).
  - Counters wrap at 2^32 and reset to 0.
- When undefined: the port and counters are absent, and arbitration behaviour is identical.

Decomposition:
- Shared package/defines: REQ_W formula, field offset constants (CMD_FLAG_BIT, NP_BIT, LEN_LSB), FSM state encodings.
- One sub-module: mcif_wr_arb_idfifo, a synchronous FIFO of $clog2(NUM_REQ)-bit IDs with full and empty flags.

Test Plan:
- Single requester 1, non-posted command with length 3, MCIF always ready:
  - Command appears 1 cycle after req_vld, then 4 data beats.
  - Return to IDLE, RR pointer becomes 2.
  - Completion pulse drives req_complete = 4'b0010.
- Requesters 0 and 2 both eligible from reset:
  - Grant order 0, 2, 0, 2.
  - No data beat of one requester ever interleaves with the other's burst.
- MCIF rdy toggles 1-0-1 during a 16-beat burst (LEN_W=4, length 15):
  - Exactly 16 data handshakes and no beat loss.
  - pd stable while vld=1 and rdy=0.
- Four non-posted bursts from requesters 3, 1, 0, 2 with no completions yet:
  - A fifth non-posted command is held off (req_rdy=0).
  - The first completion unblocks it.
  - Completions route in order 3, 1, 0, 2.
- Completion pulse with the FIFO empty -> arb_err=1, no req_complete pulse.
- rst_n asserted mid-burst in DATA:
  - All outputs 0, FIFO empty, RR pointer 0.
  - Next grant starts from requester 0.
  - With MCIF_WR_ARB_PERF_EN, perf_beats is 0.
